// File: rtl/torque_ramp_ctrl_pkg.sv
// drive_pkg: shared types for the drive command path and the torque display.
//   direc_t      - display direction encoding (also used by the display stage)
//   ramp_state_t - ramp controller states
//   TORQUE_MAX   - top torque level
//   torque_step  - one saturating torque step up or down
package drive_pkg;

    typedef enum logic [1:0] {
        DIR_FWD   = 2'b00,
        DIR_REV   = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } direc_t;

    localparam logic [1:0] TORQUE_MAX = 2'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        RAMP_DOWN = 3'd2,
        SWITCH    = 3'd3,
        HOLD      = 3'd4
    } ramp_state_t;

    // Torque never leaves 0..TORQUE_MAX, even if asked to step past an end.
    function automatic logic [1:0] torque_step(input logic [1:0] t, input logic up);
        if (up)
            return (t == TORQUE_MAX) ? t : t + 2'd1;
        else
            return (t == 2'd0) ? t : t - 2'd1;
    endfunction

endpackage

// File: rtl/torque_ramp_ctrl_if.sv
// torque_ramp_ctrl_if: drive command handshake from the switch/key front end.
//   cmd_valid  - command present (master -> slave)
//   cmd_ready  - slave can accept this cycle (slave -> master)
//   cmd_direc  - requested direction
//   cmd_torque - requested torque level 0..3
interface torque_ramp_ctrl_if;
    import drive_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    direc_t     cmd_direc;
    logic [1:0] cmd_torque;

    modport master (output cmd_valid, cmd_direc, cmd_torque, input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_direc, cmd_torque, output cmd_ready);
endinterface

// File: rtl/torque_ramp_ctrl_tick.sv
// ramp_tick_gen: ramp step timer.
//   clk, rst_n - clock, synchronous active-low reset
//   clr        - restart the count from zero
//   run        - count only while a ramp is in progress; holds 0 otherwise
//   tick       - one-cycle pulse every TICK_DIV running cycles
module ramp_tick_gen #(
    parameter int TICK_DIV = 12_500_000,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr || !run || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = run && (cnt == LAST);
endmodule

// File: rtl/torque_ramp_ctrl.sv
// torque_ramp_ctrl: slews display torque one level per ramp tick and only
// changes direction once torque has reached zero.
//   clk, rst_n    - clock, synchronous active-low reset
//   cmd           - command handshake (slave side)
//   estop         - emergency stop, level-sensitive, overrides commands
//   enable        - display enable, high while torque is nonzero
//   direc, torque - current direction / torque to the display
//   busy          - ramp in progress
//   fault         - latched e-stop fault
// Build option: TORQUE_RAMP_ESTOP_LATCH_EN latches fault on estop; only a
// zero-torque command clears it. Without it, fault is tied 0.
module torque_ramp_ctrl
    import drive_pkg::*;
#(
    parameter int TICK_DIV = 12_500_000,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic                clk,
    input  logic                rst_n,
    torque_ramp_ctrl_if.slave   cmd,
    input  logic                estop,
    output logic                enable,
    output direc_t              direc,
    output logic [1:0]          torque,
    output logic                busy,
    output logic                fault
);
    ramp_state_t state;
    direc_t      tgt_direc;
    logic [1:0]  tgt_torque;
    logic [1:0]  nxt_torque;
    logic        settled, accept, tick;

    assign settled = (state == IDLE) || (state == HOLD);
    assign busy    = !settled;

`ifdef TORQUE_RAMP_ESTOP_LATCH_EN
    logic fault_q;
    assign cmd.cmd_ready = fault_q ? !estop : (settled && !estop);
    assign fault         = fault_q;
`else
    assign cmd.cmd_ready = settled && !estop;
    assign fault         = 1'b0;
`endif

    assign accept     = cmd.cmd_valid && cmd.cmd_ready;
    // SWITCH steps down like RAMP_DOWN.
    assign nxt_torque = torque_step(torque, state == RAMP_UP);

    ramp_tick_gen #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept || estop),
        .run  (busy),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            direc      <= DIR_FWD;
            torque     <= 2'd0;
            enable     <= 1'b0;
            tgt_direc  <= DIR_FWD;
            tgt_torque <= 2'd0;
`ifdef TORQUE_RAMP_ESTOP_LATCH_EN
            fault_q    <= 1'b0;
`endif
        end else if (estop) begin
            // Drop torque at once but keep direction so the display stays put.
            state      <= IDLE;
            torque     <= 2'd0;
            enable     <= 1'b0;
            tgt_direc  <= direc;
            tgt_torque <= 2'd0;
`ifdef TORQUE_RAMP_ESTOP_LATCH_EN
            fault_q    <= 1'b1;
`endif
        end else if (accept) begin
`ifdef TORQUE_RAMP_ESTOP_LATCH_EN
            // Faulted: a zero-torque command clears it, anything else is dropped.
            if (fault_q) begin
                if (cmd.cmd_torque == 2'd0) begin
                    fault_q    <= 1'b0;
                    direc      <= cmd.cmd_direc;
                    tgt_direc  <= cmd.cmd_direc;
                    tgt_torque <= 2'd0;
                    state      <= IDLE;
                end
            end else
`endif
            begin
                tgt_direc  <= cmd.cmd_direc;
                tgt_torque <= cmd.cmd_torque;
                if (state == IDLE) begin
                    direc <= cmd.cmd_direc;
                    state <= (cmd.cmd_torque == 2'd0) ? IDLE : RAMP_UP;
                end else if (cmd.cmd_direc != direc)
                    state <= SWITCH;
                else if (cmd.cmd_torque > torque)
                    state <= RAMP_UP;
                else if (cmd.cmd_torque < torque)
                    state <= RAMP_DOWN;
            end
        end else if (tick) begin
            torque <= nxt_torque;
            enable <= (nxt_torque != 2'd0);
            if (state == SWITCH) begin
                // Direction flips on the same edge torque reaches zero.
                if (nxt_torque == 2'd0) begin
                    direc <= tgt_direc;
                    state <= (tgt_torque != 2'd0) ? RAMP_UP : IDLE;
                end
            end else if (nxt_torque == tgt_torque)
                state <= (tgt_torque == 2'd0) ? IDLE : HOLD;
        end
    end
endmodule
